// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU controller: FSM states, ISA opcode/op fields,
// datapath select codes and the instruction classes the decoder reports.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  // ALUop is taken straight from IR[12:11]; these name its meaning.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ARITH   = 3'd3,  // ADD and AND: read Rn and Rm, write Rd
    CLS_CMP     = 3'd4,
    CLS_MVN     = 3'd5
  } instr_class_e;

  function automatic instr_class_e classify(input logic [2:0] opcode,
                                            input logic [1:0] op);
    instr_class_e cls;
    cls = CLS_ILLEGAL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
      else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD, OP_AND: cls = CLS_ARITH;
        OP_CMP:         cls = CLS_CMP;
        default:        cls = CLS_MVN;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits the IR into register/shift/op
// fields, sign-extends the immediates and classifies the instruction.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0]  ir,
  output logic [2:0]   rn,
  output logic [2:0]   rd,
  output logic [2:0]   rm,
  output logic [1:0]   sh,
  output logic [1:0]   op,
  output logic [15:0]  sximm5,
  output logic [15:0]  sximm8,
  output instr_class_e iclass
);

  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign iclass = classify(ir[15:13], ir[12:11]);

endmodule

// File: rtl/cpu_controller.sv
// Instruction register and multi-cycle control FSM driving the 16-bit
// datapath; handshakes with the top level through s (start) and w (idle).
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  logic [15:0]  ir;
  logic [2:0]   rn, rd, rm;
  instr_class_e iclass;
  state_e       state, state_next;

  assign w = (state == S_WAIT);

  // The IR only accepts a new word while idle, so it is stable for the
  // whole instruction; a load together with s is seen by DECODE.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset)          ir <= '0;
    else if (load && w) ir <= in;
  end

  instr_decoder u_decoder (
    .ir     (ir),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (shift),
    .op     (ALUop),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .iclass (iclass)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    state_next = state;
    readnum    = 3'd0;
    writenum   = 3'd0;
    write      = 1'b0;
    vsel       = VSEL_C;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;

    unique case (state)
      S_WAIT: begin
        if (s) state_next = S_DECODE;
      end
      S_DECODE: begin
        unique case (iclass)
          CLS_MOV_IMM:          state_next = S_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN: state_next = S_GET_B;
          CLS_ARITH, CLS_CMP:   state_next = S_GET_A;
          default:              state_next = S_WAIT;
        endcase
      end
      S_WRITE_IMM: begin
        writenum   = rn;
        vsel       = VSEL_IMM8;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = S_ALU;
      end
      S_ALU: begin
        // Single-operand instructions never loaded A, so force it to zero.
        asel = (iclass == CLS_MOV_REG) || (iclass == CLS_MVN);
        if (iclass == CLS_CMP) begin
          loads      = 1'b1;
          state_next = S_WAIT;
        end else begin
          loadc      = 1'b1;
          state_next = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum   = rd;
        vsel       = VSEL_C;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      default: state_next = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: a table of whole-instruction vectors
// plus hand-stepped sequences for per-state outputs, restart and reset.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load, s;
  logic        w, write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;

  int checks = 0;
  int errors = 0;

  cpu_controller dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          latency;
    logic        wrote;
    logic [2:0]  wnum;
    logic        saw_loada;
    logic        saw_loads;
    logic        saw_asel;
    logic [15:0] exp_sximm8;
    logic [15:0] exp_sximm5;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] enables();
    return {write, loada, loadb, loadc, loads, asel, bsel};
  endfunction

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'hD007, 3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0007};
    vecs[1] = '{16'hD1FF, 3, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF};
    vecs[2] = '{16'hA148, 6, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0048, 16'h0008};
    vecs[3] = '{16'hA900, 5, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{16'hB860, 5, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 16'h0060, 16'h0000};
    vecs[5] = '{16'hC0E5, 5, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 16'hFFE5, 16'h0005};
    vecs[6] = '{16'hB3BF, 6, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 16'hFFBF, 16'hFFFF};
    vecs[7] = '{16'h0000, 2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[8] = '{16'hE0FF, 2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF};
    vecs[9] = '{16'hC800, 2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};

    reset = 1'b1; in = '0; load = 1'b0; s = 1'b0;
    #1;
    check("reset_w", w, 1);
    check("reset_en", enables(), 0);
    check("reset_sximm8", sximm8, 16'h0000);
    check("reset_rw", {readnum, writenum, vsel}, 0);
    step(); step();
    reset = 1'b0;
    step(); step();
    check("hold_w", w, 1);
    check("hold_en", enables(), 0);

    // MOV R0,#7 with load and s on the same edge
    in = 16'hD007; load = 1'b1; s = 1'b1;
    step();
    load = 1'b0; s = 1'b0;
    check("mov_decode_w", w, 0);
    check("mov_decode_en", enables(), 0);
    step();
    check("mov_wimm_writenum", writenum, 0);
    check("mov_wimm_vsel", vsel, 2'b10);
    check("mov_wimm_write", write, 1);
    check("mov_wimm_sximm8", sximm8, 16'h0007);
    step();
    check("mov_done_w", w, 1);

    // ADD R2,R1,R0,LSL#1 stepped state by state
    in = 16'hA148; load = 1'b1; s = 1'b1;
    step();
    load = 1'b0; s = 1'b0;
    step();
    check("add_geta", {readnum, loada, loadb}, {3'd1, 2'b10});
    step();
    check("add_getb", {readnum, loada, loadb}, {3'd0, 2'b01});
    check("add_getb_shift", shift, 2'b01);
    step();
    check("add_alu", {asel, bsel, loadc, loads}, 4'b0010);
    check("add_alu_op", ALUop, 2'b00);
    step();
    check("add_wreg", {writenum, vsel, write}, {3'd2, 2'b00, 1'b1});
    step();
    check("add_done_w", w, 1);

    // MVN R3,R0 with an ignored load during GET_B
    in = 16'hB860; load = 1'b1; s = 1'b1;
    step();
    load = 1'b0; s = 1'b0;
    step();
    check("mvn_getb", {loada, loadb}, 2'b01);
    in = 16'hD007; load = 1'b1;
    step();
    load = 1'b0;
    check("mvn_alu", {asel, loadc, ALUop}, {1'b1, 1'b1, 2'b11});
    check("mvn_ir_kept", sximm8, 16'h0060);
    step();
    check("mvn_wreg", {writenum, write}, {3'd3, 1'b1});
    step();
    check("mvn_done_w", w, 1);

    // Reset asserted while in ALU: outputs drop without a clock edge
    in = 16'hB860; load = 1'b1; s = 1'b1;
    step();
    load = 1'b0; s = 1'b0;
    step(); step();
    check("rst_pre_loadc", loadc, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_w", w, 1);
    check("rst_async_loadc", loadc, 0);
    check("rst_async_ir", sximm8, 16'h0000);
    step();
    reset = 1'b0;
    begin
      logic any_write;
      any_write = 1'b0;
      for (int i = 0; i < 4; i++) begin
        step();
        any_write |= write;
      end
      check("rst_no_write", any_write, 0);
    end

    // s held high restarts on the cycle after returning to WAIT
    in = 16'hD1FF; load = 1'b1; s = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    check("hold_s_back_w", w, 1);
    step();
    check("hold_s_restart_w", w, 0);
    s = 1'b0;
    step(); step();
    check("hold_s_final_w", w, 1);

    // Table-driven whole-instruction vectors
    for (int v = 0; v < 10; v++) begin
      int         edges;
      logic       wrote, sa, ss, sasel;
      logic [2:0] wn;
      wrote = 1'b0; sa = 1'b0; ss = 1'b0; sasel = 1'b0; wn = 3'd0;
      in = vecs[v].instr; load = 1'b1; s = 1'b1;
      step();
      load = 1'b0; s = 1'b0;
      edges = 1;
      while (!w && edges < 20) begin
        if (write) begin wrote = 1'b1; wn = writenum; end
        sa    |= loada;
        ss    |= loads;
        sasel |= asel;
        step();
        edges++;
      end
      check($sformatf("v%0d_latency", v), edges, vecs[v].latency);
      check($sformatf("v%0d_wrote", v), wrote, vecs[v].wrote);
      check($sformatf("v%0d_writenum", v), wn, vecs[v].wnum);
      check($sformatf("v%0d_flags", v), {sa, ss, sasel},
            {vecs[v].saw_loada, vecs[v].saw_loads, vecs[v].saw_asel});
      check($sformatf("v%0d_sximm8", v), sximm8, vecs[v].exp_sximm8);
      check($sformatf("v%0d_sximm5", v), sximm5, vecs[v].exp_sximm5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
